// File: rtl/exe_div_ctrl_pkg.sv
// Shared definitions for the EXE-stage iterative divider sequencer.
// Contents: divide op codes (M extension, incl. W forms), FSM state
// encoding, iteration-length constants and a 32->64 sign-extend helper.
package exe_div_ctrl_pkg;

    typedef enum logic [2:0] {
        DIV_DIV   = 3'b000,
        DIV_DIVU  = 3'b001,
        DIV_REM   = 3'b010,
        DIV_REMU  = 3'b011,
        DIV_DIVW  = 3'b100,
        DIV_DIVUW = 3'b101,
        DIV_REMW  = 3'b110,
        DIV_REMUW = 3'b111
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    localparam logic [6:0] DIV_LEN64 = 7'd64;
    localparam logic [6:0] DIV_LEN32 = 7'd32;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/exe_div_ctrl_div_step.sv
// One radix-2 restoring divide iteration (purely combinational).
// Ports:
//   rem      : current partial remainder (always < dvs)
//   shf      : dividend shift register; quotient bits enter at the bottom
//   dvs      : divisor magnitude (non-zero)
//   rem_next : partial remainder after this iteration
//   shf_next : shift register after this iteration
//   q_bit    : quotient bit produced by this iteration
module exe_div_ctrl_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] shf,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] shf_next,
    output logic            q_bit
);

    // The shifted remainder needs one extra bit; because rem < dvs the
    // difference, when non-negative, always fits back into XLEN bits.
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    assign trial    = {rem, shf[XLEN-1]};
    assign diff     = trial - {1'b0, dvs};
    assign q_bit    = ~diff[XLEN];
    assign rem_next = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
    assign shf_next = {shf[XLEN-2:0], q_bit};

endmodule

// File: rtl/exe_div_ctrl.sv
// Sequencer for the multi-cycle divider beside the EXE-stage ALU.
// Accepts one DIV/DIVU/REM/REMU (or W form), stalls the front of the
// pipeline until the result is ready, then pulses done for one cycle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   e_div_valid_i   : EXE holds a divide
//   e_div_op_i      : divide op code (see exe_div_ctrl_pkg::div_op_e)
//   e_div_data1_i   : dividend
//   e_div_data2_i   : divisor
//   e_flush_i       : kill the in-flight EXE instruction
//   e_div_stall_o   : hold PC, IF/ID and ID/EXE
//   e_div_busy_o    : sequencer not idle
//   e_div_done_o    : one-cycle result-valid pulse
//   e_div_result_o  : quotient or remainder, valid with done
module exe_div_ctrl
    import exe_div_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            e_div_valid_i,
    input  logic [2:0]      e_div_op_i,
    input  logic [XLEN-1:0] e_div_data1_i,
    input  logic [XLEN-1:0] e_div_data2_i,
    input  logic            e_flush_i,
    output logic            e_div_stall_o,
    output logic            e_div_busy_o,
    output logic            e_div_done_o,
    output logic [XLEN-1:0] e_div_result_o
);

    div_state_e      state, state_next;
    logic            is_w_q, is_rem_q, neg_q, neg_r;
    logic [5:0]      cnt;
    logic [XLEN-1:0] rem_q, shf_q, dvs_q, result;

    // Operand decode for the instruction currently presented by EXE
    logic            is_w, is_uns, is_rem, a_neg, b_neg;
    logic            by_zero, ovf, special, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg, spec_res;

    always_comb begin
        is_w    = e_div_op_i[2];
        is_rem  = e_div_op_i[1];
        is_uns  = e_div_op_i[0];
        a_ext   = is_w ? (is_uns ? {32'b0, e_div_data1_i[31:0]} : sext32(e_div_data1_i[31:0]))
                       : e_div_data1_i;
        b_ext   = is_w ? (is_uns ? {32'b0, e_div_data2_i[31:0]} : sext32(e_div_data2_i[31:0]))
                       : e_div_data2_i;
        a_neg   = !is_uns && a_ext[XLEN-1];
        b_neg   = !is_uns && b_ext[XLEN-1];
        a_abs   = a_neg ? -a_ext : a_ext;
        b_abs   = b_neg ? -b_ext : b_ext;
        min_neg = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        by_zero = (b_ext == '0);
        ovf     = !is_uns && (a_ext == min_neg) && (b_ext == '1);
        special = by_zero || ovf;
        // Divide-by-zero remainder is the 32-bit dividend sign-extended for
        // every W form, so the unsigned zero-extension is not reused here.
        if (by_zero)
            spec_res = is_rem ? (is_w ? sext32(e_div_data1_i[31:0]) : e_div_data1_i) : '1;
        else
            spec_res = is_rem ? '0 : a_ext;
        accept  = (state == S_IDLE) && e_div_valid_i && !e_flush_i;
    end

    // Single restoring iteration
    logic [XLEN-1:0] rem_nx, shf_nx;
    logic            q_bit;

    exe_div_ctrl_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .shf      (shf_q),
        .dvs      (dvs_q),
        .rem_next (rem_nx),
        .shf_next (shf_nx),
        .q_bit    (q_bit)
    );

    // Sign fix-up and result select (FIX state)
    logic [XLEN-1:0] q_fix, r_fix, sel, fix_res;

    always_comb begin
        q_fix   = neg_q ? -shf_q : shf_q;
        r_fix   = neg_r ? -rem_q : rem_q;
        sel     = is_rem_q ? r_fix : q_fix;
        fix_res = is_w_q ? sext32(sel[31:0]) : sel;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (accept) state_next = special ? S_DONE : S_CALC;
            S_CALC: if (cnt == 6'd0) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (e_flush_i) state_next = S_IDLE;
    end

    assign e_div_busy_o   = (state != S_IDLE);
    assign e_div_done_o   = (state == S_DONE);
    assign e_div_stall_o  = e_div_valid_i && !e_div_done_o && !e_flush_i;
    assign e_div_result_o = result;

    always_ff @(posedge clk) begin
        if (rst) begin
            is_w_q   <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            rem_q    <= '0;
            shf_q    <= '0;
            dvs_q    <= '0;
            result   <= '0;
        end else if (accept) begin
            is_w_q   <= is_w;
            is_rem_q <= is_rem;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            cnt      <= is_w ? 6'(DIV_LEN32 - 7'd1) : 6'(DIV_LEN64 - 7'd1);
            rem_q    <= '0;
            // W dividends sit in the top half so 32 shifts leave the
            // quotient in the low half with zeros above it.
            shf_q    <= is_w ? {a_abs[31:0], 32'b0} : a_abs;
            dvs_q    <= b_abs;
            if (special) result <= spec_res;
        end else if (!e_flush_i && state == S_CALC) begin
            rem_q <= rem_nx;
            shf_q <= shf_nx;
            if (cnt != 6'd0) cnt <= cnt - 6'd1;
        end else if (!e_flush_i && state == S_FIX) begin
            result <= fix_res;
        end
    end

    // EXE must keep the divide presented until done unless it is flushed
    property p_valid_held;
        @(posedge clk) disable iff (rst)
            (state == S_CALC || state == S_FIX) && !e_flush_i |-> e_div_valid_i;
    endproperty
    a_valid_held: assert property (p_valid_held);

endmodule

// File: tb/tb_exe_div_ctrl.sv
module tb_exe_div_ctrl;
    import exe_div_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        e_div_valid_i;
    logic [2:0]  e_div_op_i;
    logic [63:0] e_div_data1_i;
    logic [63:0] e_div_data2_i;
    logic        e_flush_i;
    logic        e_div_stall_o;
    logic        e_div_busy_o;
    logic        e_div_done_o;
    logic [63:0] e_div_result_o;

    int tests = 0;
    int fails = 0;

    exe_div_ctrl #(.XLEN(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .e_div_valid_i  (e_div_valid_i),
        .e_div_op_i     (e_div_op_i),
        .e_div_data1_i  (e_div_data1_i),
        .e_div_data2_i  (e_div_data2_i),
        .e_flush_i      (e_flush_i),
        .e_div_stall_o  (e_div_stall_o),
        .e_div_busy_o   (e_div_busy_o),
        .e_div_done_o   (e_div_done_o),
        .e_div_result_o (e_div_result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic start(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        e_div_valid_i = 1'b1;
        e_div_op_i    = op;
        e_div_data1_i = a;
        e_div_data2_i = b;
    endtask

    // First edge is the accept edge; lat counts cycles from accept to done.
    task automatic wait_done(output int lat, output logic stall_ok);
        stall_ok = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!e_div_done_o && lat < 200) begin
            if (!e_div_stall_o) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int   lat;
    logic sok;

    initial begin
        vecs[0]  = '{DIV_DIV,   64'd100, 64'd7, 64'd14, 66};
        vecs[1]  = '{DIV_REM,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[2]  = '{DIV_REMU,  64'd7,   64'd2, 64'd1, 66};
        vecs[3]  = '{DIV_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66};
        vecs[4]  = '{DIV_DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[5]  = '{DIV_REM,   64'd5, 64'd0, 64'd5, 1};
        vecs[6]  = '{DIV_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[7]  = '{DIV_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[8]  = '{DIV_DIVW,  64'h1234_5678_8000_0000, 64'hABCD_EF01_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[9]  = '{DIV_DIVUW, 64'hDEAD_BEEF_FFFF_FFFE, 64'h5555_5555_0000_0002, 64'h0000_0000_7FFF_FFFF, 34};
        vecs[10] = '{DIV_DIV,   -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66};
        vecs[11] = '{DIV_REM,   -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[12] = '{DIV_REMW,  64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        vecs[13] = '{DIV_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        vecs[14] = '{DIV_REMUW, 64'h0000_0000_8000_0005, 64'hFFFF_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, 1};
        vecs[15] = '{DIV_REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 66};
        vecs[16] = '{DIV_DIV,   64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};

        rst = 1'b1;
        e_div_valid_i = 1'b0;
        e_div_op_i    = 3'b000;
        e_div_data1_i = '0;
        e_div_data2_i = '0;
        e_flush_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset done",   {63'b0, e_div_done_o},  64'd0);
        check("reset busy",   {63'b0, e_div_busy_o},  64'd0);
        check("reset stall",  {63'b0, e_div_stall_o}, 64'd0);
        check("reset result", e_div_result_o,         64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            start(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, sok);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d result", i), e_div_result_o, vecs[i].exp);
            check($sformatf("vec%0d stall held", i), {63'b0, sok}, 64'd1);
            check($sformatf("vec%0d stall at done", i), {63'b0, e_div_stall_o}, 64'd0);
            @(negedge clk);
            e_div_valid_i = 1'b0;
            @(posedge clk); #1;
            check($sformatf("vec%0d idle after", i), {62'b0, e_div_busy_o, e_div_done_o}, 64'd0);
        end

        // Flush and valid together in IDLE: no accept
        @(negedge clk);
        e_div_valid_i = 1'b1; e_div_op_i = DIV_DIV;
        e_div_data1_i = 64'd10; e_div_data2_i = 64'd2;
        e_flush_i = 1'b1;
        @(posedge clk); #1;
        check("flush in idle busy", {63'b0, e_div_busy_o}, 64'd0);
        @(negedge clk);
        e_flush_i = 1'b0; e_div_valid_i = 1'b0;

        // Flush at t+10 of a 64-bit DIV, then DIV 9/3 at t+11
        start(DIV_DIV, 64'd1000, 64'd3);
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        e_flush_i = 1'b1;
        #1;
        check("flush same-cycle stall", {63'b0, e_div_stall_o}, 64'd0);
        @(posedge clk); #1;
        check("flush busy next", {63'b0, e_div_busy_o}, 64'd0);
        check("flush no done",   {63'b0, e_div_done_o}, 64'd0);
        @(negedge clk);
        e_flush_i = 1'b0;
        e_div_op_i = DIV_DIV; e_div_data1_i = 64'd9; e_div_data2_i = 64'd3;
        wait_done(lat, sok);
        check("post-flush latency", 64'(lat), 64'd66);
        check("post-flush result", e_div_result_o, 64'd3);

        // Back-to-back with valid held high
        @(negedge clk);
        e_div_data1_i = 64'd20; e_div_data2_i = 64'd4;
        @(posedge clk); #1;
        start(DIV_DIV, 64'd20, 64'd4);
        wait_done(lat, sok);
        check("b2b first latency", 64'(lat), 64'd66);
        check("b2b first result", e_div_result_o, 64'd5);
        @(negedge clk);
        e_div_data1_i = 64'd21;
        @(posedge clk); #1;
        check("b2b idle gap", {62'b0, e_div_busy_o, e_div_done_o}, 64'd0);
        check("b2b idle stall", {63'b0, e_div_stall_o}, 64'd1);
        wait_done(lat, sok);
        check("b2b second latency", 64'(lat), 64'd66);
        check("b2b second result", e_div_result_o, 64'd5);
        check("b2b second stall held", {63'b0, sok}, 64'd1);

        // Third divide, reset at t+30
        @(negedge clk);
        e_div_data1_i = 64'd50; e_div_data2_i = 64'd5;
        @(posedge clk);
        @(posedge clk); #1;
        repeat (29) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", {63'b0, e_div_busy_o}, 64'd1);
        rst = 1'b1;
        e_div_valid_i = 1'b0;
        @(posedge clk); #1;
        check("mid reset busy",   {63'b0, e_div_busy_o},  64'd0);
        check("mid reset done",   {63'b0, e_div_done_o},  64'd0);
        check("mid reset stall",  {63'b0, e_div_stall_o}, 64'd0);
        check("mid reset result", e_div_result_o,         64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after reset no done", {63'b0, e_div_done_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
